// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus for seq_divider.
//   master : drives start, dividend, divisor; observes busy, done, quotient,
//            remainder, div_by_zero (datapath controller side)
//   slave  : the divider itself
// Parameter WIDTH must match the WIDTH of the connected seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring shift-subtract divider, one quotient bit
// per clock, with divide-by-zero detection and a start/done handshake.
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : seq_divider_if.slave
//     start (in)          launch request, sampled only in IDLE
//     dividend/divisor    operands, sampled on the accepting edge
//     busy (out)          high from accept until done deasserts
//     done (out)          one-cycle completion pulse
//     quotient/remainder  results, held until the next accept
//     div_by_zero (out)   set with done when divisor was 0
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (magnitude division with sign fix-up on the FIN edge, truncation to zero).
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  seq_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               zero_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   quotient_q, remainder_q;

  logic [WIDTH:0]     shifted, trial;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic qneg_q, rneg_q;

  always_comb begin
    dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
  end
`else
  always_comb begin
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
    quo_fix = quo_q;
    rem_fix = rem_q;
  end
`endif

  // One restoring step. The partial remainder is always below the divisor, so
  // the trial result fits in WIDTH bits when non-negative and bit WIDTH is a
  // reliable borrow flag.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            dvs_q  <= dvs_mag;
            if (bus.divisor == '0) begin
              // Preload the fixed divide-by-zero result; sign flags cleared so
              // FIN passes it through untouched.
              rem_q   <= bus.dividend;
              quo_q   <= '1;
              zero_q  <= 1'b1;
              cnt_q   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
`endif
              state_q <= FIN;
            end else begin
              rem_q   <= '0;
              quo_q   <= dvd_mag;
              zero_q  <= 1'b0;
              cnt_q   <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
              qneg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              rneg_q  <= bus.dividend[WIDTH-1];
`endif
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIN;
        end
        FIN: begin
          // First FIN edge publishes results, second returns to IDLE.
          if (!done_q) begin
            quotient_q  <= quo_fix;
            remainder_q <= rem_fix;
            dbz_q       <= zero_q;
            done_q      <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=8).
module tb_seq_divider;
  localparam int unsigned WIDTH = 8;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one division and follow it to completion.
  task automatic run_div(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input int elat);
    int e;
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clock);               // accepting edge k
    @(negedge clock);
    bus.start = 1'b0;
    chk($sformatf("%s.busy_acc", name), 32'(bus.busy), 32'd1);
    chk($sformatf("%s.dbz_clr", name), 32'(bus.div_by_zero), 32'd0);
    e = 0;
    while (!bus.done && e < 40) begin
      @(posedge clock); e++;
      @(negedge clock);
    end
    chk($sformatf("%s.lat", name), 32'(e), 32'(elat));
    chk($sformatf("%s.q", name), 32'(bus.quotient), 32'(eq));
    chk($sformatf("%s.r", name), 32'(bus.remainder), 32'(er));
    chk($sformatf("%s.dbz", name), 32'(bus.div_by_zero), 32'(edbz));
    chk($sformatf("%s.busy_fin", name), 32'(bus.busy), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk($sformatf("%s.done_pulse", name), 32'(bus.done), 32'd0);
    chk($sformatf("%s.busy_end", name), 32'(bus.busy), 32'd0);
    chk($sformatf("%s.q_hold", name), 32'(bus.quotient), 32'(eq));
    chk($sformatf("%s.dbz_hold", name), 32'(bus.div_by_zero), 32'(edbz));
  endtask

  initial begin
    int nd;
    int seen;
    n_cmp = 0; n_err = 0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.q", 32'(bus.quotient), 32'd0);
    chk("rst.r", 32'(bus.remainder), 32'd0);
    chk("rst.dbz", 32'(bus.div_by_zero), 32'd0);
    reset_n = 1'b1;

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m7_2",    8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    run_div("s_7_m2",    8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
    run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run_div("s_m56_7",   8'hC8, 8'h07, 8'hF8, 8'h00, 1'b0, 9);
`else
    run_div("u_200_7",   8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
    run_div("u_255_1",   8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run_div("u_3_9",     8'd3,   8'd9, 8'd0,  8'd3, 1'b0, 9);
    run_div("u_0_9",     8'd0,   8'd9, 8'd0,  8'd0, 1'b0, 9);
`endif
    run_div("dz_5_0",    8'd5,   8'd0, 8'hFF, 8'd5, 1'b1, 1);
    run_div("after_dz",  8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 9);

    // Start held high; operands change after acceptance.
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd3;
    @(posedge clock);               // edge k
    @(negedge clock);
    bus.dividend = 8'd50; bus.divisor = 8'd5;
    nd = 0;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (e == 11) bus.start = 1'b0;   // second accept happens at edge k+11
      if (bus.done) begin
        nd++;
        if (nd == 1) begin
          chk("hold.first_edge", 32'(e), 32'd9);
          chk("hold.first_q", 32'(bus.quotient), 32'd33);
          chk("hold.first_r", 32'(bus.remainder), 32'd1);
        end else begin
          chk("hold.second_edge", 32'(e), 32'd20);
          chk("hold.second_q", 32'(bus.quotient), 32'd10);
          chk("hold.second_r", 32'(bus.remainder), 32'd0);
        end
      end
    end
    chk("hold.n_done", 32'(nd), 32'd2);
    chk("hold.idle", 32'(bus.busy), 32'd0);

    // Reset mid-operation.
    @(negedge clock);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clock);               // edge k
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(posedge clock);    // edges k+1..k+3
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);               // edge k+4
    @(negedge clock);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.q", 32'(bus.quotient), 32'd0);
    chk("abort.r", 32'(bus.remainder), 32'd0);
    chk("abort.dbz", 32'(bus.div_by_zero), 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.done || bus.busy) seen++;
    end
    chk("abort.quiet", 32'(seen), 32'd0);
    run_div("post_rst_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
